pulse_req_scheduler: RTL and testbench
======================================

// Module: pulse_req_scheduler
// PURPOSE
//  Shares one output pulse generator between N_REQ request lines.
//  - Detects rising edges on each request line and queues one pending flag per requester.
//  - Grants queued requests round-robin.
//  - Drives a fixed-width pulse for the granted requester, then enforces an inter-pulse gap.
//  - Sits above the single-line edge/pulse stage, sequencing it for multiple sources.
// PARAMETERS
//  N_REQ    4  number of requesters (2..8)
//  PULSE_W  5  pulse_out high time in clk cycles (1..15)
//  GAP      2  forced low cycles between pulses (0..15; 0 = back-to-back allowed)
// PORTS
//  clk        in   1              system clock, all logic on posedge
//  rst        in   1              asynchronous, active-low reset
//  req_in     in   N_REQ          request lines, synchronous to clk, level signals
//  pulse_out  out  1              shared output pulse, registered
//  grant_id   out  clog2(N_REQ)   index of requester owning current/last pulse
//  busy       out  1              high in PULSE or GAP state
//  pend       out  N_REQ          pending request flags
// BEHAVIOUR
//  Reset (rst=0, async):
//   - pulse_out=0, grant_id=0, busy=0, pend=0, req_prev=0, state=IDLE.
//   - RR pointer set so that requester 0 has top priority.
//   - Reset asserted mid-pulse drops pulse_out immediately and discards all pending requests.
//  Edge detect:
//   - rise[i] = req_in[i] & ~req_prev[i]; req_prev registered every cycle.
//   - pend[i] is set on the clock edge that samples rise[i].
//   - A line held high generates only one request.
//  FSM states: IDLE, PULSE, GAP.
//   - IDLE: if pend!=0, on the next edge go to PULSE:
//       - winner = first set pend bit searching from (last grant+1) mod N_REQ;
//       - grant_id <= winner; pend[winner] cleared; pulse_out <= 1; cnt <= PULSE_W-1.
//   - PULSE: cnt decrements each cycle. At cnt==0 pulse_out <= 0, then:
//       - GAP>0: go to GAP with cnt <= GAP-1;
//       - GAP==0: act as IDLE in the same edge (immediate re-grant if pend!=0).
//   - GAP: pulse_out=0; at cnt==0 go to IDLE.
//   - busy = (state!=IDLE).
//  Latency: edge sampled at E0 -> pend set at E0 -> pulse_out high E1..E1+PULSE_W (when idle).
//  Simultaneous set and clear of the same pend bit (new edge on the grant edge): set wins.
//   - The request is re-queued and served in a later rotation.
//  Multiple rises in one cycle: all are queued; served in RR order from last grant+1.
//  Edge while pend[i] already set: merged (one pulse served).
//  grant_id holds its value after the pulse until the next grant.
// CONFIGURATION
//  Macro PULSE_SCHED_OVERRUN_EN:
//   - defined: adds output ovr_cnt[7:0], reset 0.
//       - Increments (saturating at 255) on each cycle where rise[i] & pend[i] for any i.
//       - Multiple hits in one cycle count as 1.
//   - undefined: port and counter absent; merged edges are silently dropped.
// STRUCTURE
//  Shared header pulse_sched_defs.vh:
//   - state encodings ST_IDLE=2'd0, ST_PULSE=2'd1, ST_GAP=2'd2;
//   - clog2 function;
//   - counter width CNT_W=4.
//  Sub-module rr_arbiter (N_REQ param):
//   - inputs req vector and last-grant index;
//   - outputs one-hot gnt and its index; purely combinational.
//  Top holds edge detect, pend register, FSM, counter, optional overrun counter.
// TESTING
//  1. Reset then single rise on req_in[0]
//     -> pulse_out high exactly 5 cycles starting the edge after pend[0] sets; grant_id=0; busy 7 cycles.
//  2. req_in=4'b1111 rise in one cycle
//     -> four pulses in order 0,1,2,3, each 5 high / 2 low; pend clears one bit per grant.
//  3. After grant 2, rises on req 1 and 3 together -> req 3 served before req 1.
//  4. req_in[1] held high 40 cycles -> exactly one pulse; re-rise on the grant edge -> second pulse later.
//  5. rst low during 3rd cycle of pulse
//     -> pulse_out=0 and pend=0 asynchronously; no pulse after release until a new rise.
//  6. With PULSE_SCHED_OVERRUN_EN: three rises on req 2 while pending
//     -> ovr_cnt=3; GAP=0 build shows back-to-back pulses with no low cycle.

Source files
------------

// File: rtl/pulse_req_scheduler_pkg.sv
// Shared definitions for pulse_req_scheduler: state encodings, counter width
// and a constant clog2 helper.
package pulse_req_scheduler_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit searching
// upward from (last grant + 1) mod N_REQ, wrapping around.
module rr_arbiter
  import pulse_req_scheduler_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        i_req,
  input  logic [clog2(N_REQ)-1:0] i_last,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [clog2(N_REQ)-1:0] o_idx
);

  localparam int IDX_W = clog2(N_REQ);

  int   w_j;
  logic w_found;

  // Rotating priority search; the first hit after the last grant wins.
  always_comb begin
    o_gnt   = {N_REQ{1'b0}};
    o_idx   = {IDX_W{1'b0}};
    w_found = 1'b0;
    w_j     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_j = (int'(i_last) + i) % N_REQ;
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IDX_W'(w_j);
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/pulse_req_scheduler.sv
// Shares one pulse generator between N_REQ edge-triggered requesters, granted
// round-robin. Optional overrun counter enabled by macro PULSE_SCHED_OVERRUN_EN.
module pulse_req_scheduler
  import pulse_req_scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int PULSE_W = 5,
  parameter int GAP     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_in,
  output logic                    pulse_out,
  output logic [clog2(N_REQ)-1:0] grant_id,
  output logic                    busy,
  output logic [N_REQ-1:0]        pend
`ifdef PULSE_SCHED_OVERRUN_EN
  ,
  output logic [7:0]              ovr_cnt
`endif
);

  localparam int IDX_W = clog2(N_REQ);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [N_REQ-1:0]   r_req_prev;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   w_last_nxt;
  logic [IDX_W-1:0]   w_grant_nxt;
  logic               w_pulse_nxt;
  logic               w_do_grant;
  logic [N_REQ-1:0]   w_clr;
  logic [N_REQ-1:0]   w_rise;
  logic [N_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;

  assign w_rise = req_in & ~r_req_prev;
  assign busy   = (r_state != ST_IDLE);

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_req  (pend),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_gnt_idx)
  );

  // Next-state logic; a pulse end with GAP==0 falls straight into a new grant.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = pulse_out;
    w_grant_nxt = grant_id;
    w_last_nxt  = r_last;
    w_clr       = {N_REQ{1'b0}};
    w_do_grant  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_do_grant = |pend;
      end
      ST_PULSE: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_pulse_nxt = 1'b0;
          if (GAP > 0) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = CNT_W'(GAP - 1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_do_grant  = |pend;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pulse_nxt = 1'b0;
      end
    endcase
    if (w_do_grant) begin
      w_state_nxt = ST_PULSE;
      w_pulse_nxt = 1'b1;
      w_cnt_nxt   = CNT_W'(PULSE_W - 1);
      w_grant_nxt = w_gnt_idx;
      w_last_nxt  = w_gnt_idx;
      w_clr       = w_gnt;
    end else begin
      w_clr = {N_REQ{1'b0}};
    end
  end

  // State, counter, outputs and pending flags; a fresh rise beats a grant clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_req_prev <= {N_REQ{1'b0}};
      r_last     <= IDX_W'(N_REQ - 1);
      pulse_out  <= 1'b0;
      grant_id   <= {IDX_W{1'b0}};
      pend       <= {N_REQ{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_req_prev <= req_in;
      r_last     <= w_last_nxt;
      pulse_out  <= w_pulse_nxt;
      grant_id   <= w_grant_nxt;
      pend       <= (pend & ~w_clr) | w_rise;
    end
  end

`ifdef PULSE_SCHED_OVERRUN_EN
  // Saturating count of cycles where any edge lands on an already pending line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_cnt <= 8'd0;
    end else if ((|(w_rise & pend)) && (ovr_cnt != 8'hFF)) begin
      ovr_cnt <= ovr_cnt + 8'd1;
    end else begin
      ovr_cnt <= ovr_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_req_scheduler.sv
// Directed and random checks of pulse_req_scheduler against a countdown-based
// reference model of the scheduling rules.
module tb_pulse_req_scheduler;

  localparam int N  = 4;
  localparam int PW = 5;
  localparam int GP = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_in = '0;
  logic         pulse_out;
  logic [1:0]   grant_id;
  logic         busy;
  logic [N-1:0] pend;
`ifdef PULSE_SCHED_OVERRUN_EN
  logic [7:0]   ovr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_pend [N];
  bit m_prev [N];
  int m_hi, m_gap, m_last, m_grant, m_ovr;

  // observations
  logic prev_pulse;
  int   gq[$];
  int   hi_cycles, busy_cycles;

  always #5 clk = ~clk;

  pulse_req_scheduler #(.N_REQ(N), .PULSE_W(PW), .GAP(GP)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .req_in    (req_in),
    .pulse_out (pulse_out),
    .grant_id  (grant_id),
    .busy      (busy),
    .pend      (pend)
`ifdef PULSE_SCHED_OVERRUN_EN
    ,
    .ovr_cnt   (ovr_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_prev[i] = 1'b0;
    end
    m_hi = 0; m_gap = 0; m_last = N - 1; m_grant = 0; m_ovr = 0;
  endtask

  task automatic try_grant();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (m_pend[idx]) begin
        m_grant = idx; m_last = idx; m_pend[idx] = 1'b0; m_hi = PW;
        return;
      end
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    bit rise [N];
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      rise[i] = r[i] && !m_prev[i];
      if (rise[i] && m_pend[i]) hit = 1'b1;
    end
    if (hit && m_ovr < 255) m_ovr++;
    if (m_hi > 0) begin
      m_hi--;
      if (m_hi == 0) begin
        if (GP > 0) m_gap = GP;
        else try_grant();
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      try_grant();
    end
    for (int i = 0; i < N; i++) begin
      if (rise[i]) m_pend[i] = 1'b1;
      m_prev[i] = r[i];
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] mp;
    for (int i = 0; i < N; i++) mp[i] = m_pend[i];
    chk({tag, ".pulse"}, 32'(pulse_out), 32'(m_hi > 0));
    chk({tag, ".busy"},  32'(busy),      32'((m_hi > 0) || (m_gap > 0)));
    chk({tag, ".pend"},  32'(pend),      32'(mp));
    chk({tag, ".grant"}, 32'(grant_id),  32'(m_grant));
`ifdef PULSE_SCHED_OVERRUN_EN
    chk({tag, ".ovr"},   32'(ovr_cnt),   32'(m_ovr));
`endif
    if (pulse_out === 1'b1 && prev_pulse !== 1'b1) gq.push_back(int'(grant_id));
    prev_pulse = pulse_out;
    if (pulse_out === 1'b1) hi_cycles++;
    if (busy === 1'b1) busy_cycles++;
  endtask

  task automatic cycle(input string tag, input logic [N-1:0] r);
    req_in = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    req_in = '0;
    model_reset();
    #1;
    check_all("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gq.delete();
    prev_pulse = 1'b0;
    hi_cycles = 0;
    busy_cycles = 0;
  endtask

  initial begin
    logic [N-1:0] r;
    model_reset();
    prev_pulse = 1'b0;

    // reset state
    do_reset();
    chk("rst.pulse0", 32'(pulse_out), 32'd0);
    chk("rst.pend0",  32'(pend),      32'd0);

    // single rise on req 0
    cycle("t1", 4'b0001);
    idle("t1", 12);
    chk("t1.hi_cycles",   32'(hi_cycles),   32'd5);
    chk("t1.busy_cycles", 32'(busy_cycles), 32'd7);
    chk("t1.npulses",     32'(gq.size()),   32'd1);
    if (gq.size() > 0) chk("t1.gid", 32'(gq[0]), 32'd0);

    // all four rise together
    do_reset();
    cycle("t2", 4'b1111);
    idle("t2", 40);
    chk("t2.npulses", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("t2.order", 32'(gq[i]), 32'(i));
    chk("t2.hi_cycles", 32'(hi_cycles), 32'd20);

    // after grant 2, rises on 1 and 3 -> 3 first
    do_reset();
    cycle("t3", 4'b0100);
    idle("t3", 10);
    cycle("t3", 4'b1010);
    idle("t3", 20);
    chk("t3.npulses", 32'(gq.size()), 32'd3);
    if (gq.size() == 3) begin
      chk("t3.first",  32'(gq[1]), 32'd3);
      chk("t3.second", 32'(gq[2]), 32'd1);
    end

    // held line gives one pulse
    do_reset();
    for (int i = 0; i < 40; i++) cycle("t4a", 4'b0010);
    idle("t4a", 10);
    chk("t4a.npulses", 32'(gq.size()), 32'd1);

    // re-rise on the grant edge of req 1 is re-queued
    do_reset();
    cycle("t4b", 4'b0011);
    idle("t4b", 8);
    for (int i = 0; i < 20; i++) cycle("t4b", 4'b0010);
    chk("t4b.npulses", 32'(gq.size()), 32'd3);
    if (gq.size() == 3) begin
      chk("t4b.g0", 32'(gq[0]), 32'd0);
      chk("t4b.g1", 32'(gq[1]), 32'd1);
      chk("t4b.g2", 32'(gq[2]), 32'd1);
    end

    // async reset in third cycle of a pulse, with req 2 pending
    do_reset();
    cycle("t5", 4'b0001);
    cycle("t5", 4'b0100);
    idle("t5", 2);
    chk("t5.pre_pulse", 32'(pulse_out), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5.async_pulse", 32'(pulse_out), 32'd0);
    chk("t5.async_pend",  32'(pend),      32'd0);
    chk("t5.async_busy",  32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gq.delete();
    prev_pulse = 1'b0;
    idle("t5", 15);
    chk("t5.npulses", 32'(gq.size()), 32'd0);

`ifdef PULSE_SCHED_OVERRUN_EN
    // three re-rises of req 2 while still pending
    do_reset();
    cycle("t6", 4'b0101);
    cycle("t6", 4'b0000);
    for (int i = 0; i < 3; i++) begin
      cycle("t6", 4'b0100);
      cycle("t6", 4'b0000);
    end
    chk("t6.ovr3", 32'(ovr_cnt), 32'd3);
    idle("t6", 20);
`endif

    // random traffic against the model
    do_reset();
    r = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      end
      cycle("rnd", r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
